regex_stream_processor: RTL

Packet-framed streaming front end for the generated `regex_main` matcher core, carrying `LANES` bytes per beat under valid/ready flow control. It tracks each beat through the core's pipeline and flushes the core at every packet end. After each packet it resets the core and pushes a per-packet result record (matched flag, match-beat count, first matching beat) into a small result FIFO. It also keeps running packet and match statistics. It sits between the byte-stream source and the result consumer, in place of the bare single-stream, always-enabled processor wrapper.

---
 rtl/regex_stream_processor.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/regex_stream_processor.sv
// Packet-framed front end for a streaming literal matcher: flushes the core at each
// packet end, attributes matches to real beats and queues one result record per packet.

module regex_main #(
  parameter int LANES   = 3,
  parameter int LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               enable,
  input  logic [8*LANES-1:0] i,
  output logic               o
);
  localparam int PLEN = 3;
  localparam logic [8*PLEN-1:0] PATTERN = "abc";
  localparam int HW = 8 * (PLEN - 1);
  localparam int SW = 8 * (LANES + PLEN - 1);

  logic [HW-1:0]    hist;
  logic [SW-1:0]    seq;
  logic [LANES-1:0] lane_hit;
  logic             hit;

  // Oldest byte sits in the low bits: history first, then beat bytes 0..LANES-1.
  assign seq = {i, hist};

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    lane_hit = '0;
    for (int j = 0; j < LANES; j++) begin
      lane_hit[j] = 1'b1;
      for (int p = 0; p < PLEN; p++)
        if (seq[8*(j+p) +: 8] != PATTERN[8*(PLEN-1-p) +: 8]) lane_hit[j] = 1'b0;
    end
    hit = |lane_hit;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)      hist <= '0;
    else if (clear)  hist <= '0;
    else if (enable) hist <= seq[SW-1 -: HW];

  if (LATENCY == 0) begin : g_comb
    assign o = hit;
  end else begin : g_pipe
    logic [LATENCY-1:0] pipe;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)      pipe <= '0;
      else if (clear)  pipe <= '0;
      else if (enable) begin
        pipe[0] <= hit;
        for (int k = 1; k < LATENCY; k++) pipe[k] <= pipe[k-1];
      end
    assign o = pipe[LATENCY-1];
  end
endmodule

module regex_stream_processor #(
  parameter int LANES         = 3,
  parameter int MATCH_LATENCY = 1,
  parameter int COUNT_WIDTH   = 16,
  parameter int BEAT_WIDTH    = 16,
  parameter int RESULT_DEPTH  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mode,
  input  logic [8*LANES-1:0]     in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   res_matched,
  output logic [COUNT_WIDTH-1:0] res_count,
  output logic [BEAT_WIDTH-1:0]  res_first_beat,
  output logic                   res_overflow,
  output logic [31:0]            stat_packets,
  output logic [31:0]            stat_matches,
  output logic                   busy
);
  typedef enum logic [1:0] {STREAM, FLUSH, REPORT, CLEAR} state_t;
  typedef struct packed {logic live; logic [BEAT_WIDTH-1:0] idx;} tag_t;
  typedef struct packed {
    logic                   matched;
    logic [COUNT_WIDTH-1:0] count;
    logic [BEAT_WIDTH-1:0]  first_beat;
    logic                   overflow;
  } rec_t;

  localparam int FW = $clog2(MATCH_LATENCY + 2);
  localparam int AW = $clog2(RESULT_DEPTH);

  state_t                 state, next_state;
  logic                   accept, core_enable, core_clear, core_o, count_event;
  logic                   push, pop, full, eff_mode;
  logic [8*LANES-1:0]     core_data;
  logic [FW-1:0]          flush_cnt;
  tag_t                   tag_in, tag_out;
  logic                   skip, started, mode_q, overflow;
  logic [BEAT_WIDTH-1:0]  beat_idx, first_beat;
  logic [COUNT_WIDTH-1:0] match_count;
  rec_t                   record, last_rec;
  rec_t                   mem [RESULT_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            fill;

  assign accept   = in_valid && in_ready;
  assign eff_mode = started ? mode_q : mode;
  assign busy     = (state != STREAM) || started;

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state    <= STREAM;
      in_ready <= 1'b0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state == STREAM);
    end

  always_comb begin
    next_state = state;
    unique case (state)
      STREAM: if (accept && in_last) next_state = (MATCH_LATENCY > 0) ? FLUSH : REPORT;
      FLUSH:  if (flush_cnt == FW'(MATCH_LATENCY - 1)) next_state = REPORT;
      REPORT: if (!full) next_state = CLEAR;
      CLEAR:  next_state = STREAM;
      default: next_state = STREAM;
    endcase
  end

  always_comb begin
    core_enable = 1'b0;
    core_data   = '0;
    core_clear  = 1'b0;
    push        = 1'b0;
    unique case (state)
      STREAM: begin
        core_enable = accept && !skip;
        core_data   = in_data;
      end
      FLUSH:  core_enable = 1'b1;
      REPORT: push = !full;
      CLEAR:  core_clear = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset)               flush_cnt <= '0;
    else if (state == FLUSH)  flush_cnt <= flush_cnt + 1'b1;
    else                      flush_cnt <= '0;

  regex_main #(.LANES(LANES), .LATENCY(MATCH_LATENCY)) u_core (
    .clk    (clock),
    .rst_n  (reset),
    .clear  (core_clear),
    .enable (core_enable),
    .i      (core_data),
    .o      (core_o)
  );

  // Tags ride alongside the core pipeline so each core output is tied to the beat that caused it.
  assign tag_in = '{live: (state == STREAM), idx: beat_idx};

  if (MATCH_LATENCY == 0) begin : g_tag_comb
    assign tag_out = tag_in;
  end else begin : g_tag_pipe
    tag_t pipe [MATCH_LATENCY];
    always_ff @(posedge clock or negedge reset)
      if (!reset || core_clear) begin
        for (int k = 0; k < MATCH_LATENCY; k++) pipe[k] <= '0;
      end else if (core_enable) begin
        pipe[0] <= tag_in;
        for (int k = 1; k < MATCH_LATENCY; k++) pipe[k] <= pipe[k-1];
      end
    assign tag_out = pipe[MATCH_LATENCY-1];
  end

  // A result is consumed as it shifts out of the core; skip suppresses anything after the first hit.
  assign count_event = core_enable && tag_out.live && core_o && !skip;

  always_ff @(posedge clock or negedge reset)
    if (!reset || core_clear) begin
      skip        <= 1'b0;
      started     <= 1'b0;
      mode_q      <= 1'b0;
      overflow    <= 1'b0;
      beat_idx    <= '0;
      first_beat  <= '1;
      match_count <= '0;
    end else begin
      if (accept) begin
        started <= 1'b1;
        if (!started) mode_q <= mode;
        if (&beat_idx) overflow <= 1'b1;
        else           beat_idx <= beat_idx + 1'b1;
      end
      if (count_event) begin
        if (match_count == '0) first_beat <= tag_out.idx;
        if (!(&match_count))   match_count <= match_count + 1'b1;
        if (eff_mode)          skip <= 1'b1;
      end
    end

  assign record = '{matched: (match_count != '0), count: match_count,
                    first_beat: first_beat, overflow: overflow};

  assign full      = (fill == (AW+1)'(RESULT_DEPTH));
  assign res_valid = (fill != '0);
  assign pop       = res_valid && res_ready;

  // NOTE: the record storage has no reset; its contents are never visible until written.
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= record;

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill         <= '0;
      last_rec     <= '0;
      stat_packets <= '0;
      stat_matches <= '0;
    end else begin
      if (push) begin
        wr_ptr       <= wr_ptr + 1'b1;
        stat_packets <= stat_packets + 1'b1;
        if (record.matched) stat_matches <= stat_matches + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_rec <= mem[rd_ptr];
      end
      unique case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: ;
      endcase
    end

  // An empty FIFO keeps showing the most recently popped record.
  assign {res_matched, res_count, res_first_beat, res_overflow} =
      res_valid ? mem[rd_ptr] : last_rec;
endmodule
